// File: rtl/pattern_seq_ctrl_if.sv
// pattern_seq_ctrl_if: control handshake and pattern outputs of the pattern sequencer
interface pattern_seq_ctrl_if;
  logic        start;
  logic [3:0]  repeat_cnt;
  logic        pause;
  logic [15:0] Q;
  logic        SER;
  logic [3:0]  bit_idx;
  logic        busy;
  logic        done;
  modport master (output start, repeat_cnt, pause, input Q, SER, bit_idx, busy, done);
  modport slave  (input start, repeat_cnt, pause, output Q, SER, bit_idx, busy, done);
endinterface

// File: rtl/pattern_seq_ctrl.sv
// pattern_seq_ctrl: shifts a fixed 16-bit pattern out MSB-first at CLK/DIV, repeated on request; PATTERN_ROTATE_EN turns the shift into a rotate
module pattern_seq_ctrl #(
  parameter logic [15:0] N     = 16'hACE1,
  parameter int          DIV   = 4,
  parameter int          CNT_W = 8
) (
  input  logic CLK,
  input  logic n_RESET,
  pattern_seq_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;
  localparam logic [CNT_W-1:0] DIV_M1 = CNT_W'(DIV - 1);
  state_t           state_q, state_d;
  logic [15:0]      q_q, q_d;
  logic [3:0]       bit_idx_q, bit_idx_d;
  logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
  logic [3:0]       rep_rem_q, rep_rem_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             fill;
`ifdef PATTERN_ROTATE_EN
  assign fill = q_q[15];
`else
  assign fill = 1'b0;
`endif
  // next-state and register updates for the run sequencer
  always_comb begin
    state_d   = state_q;
    q_d       = q_q;
    bit_idx_d = bit_idx_q;
    div_cnt_d = div_cnt_q;
    rep_rem_d = rep_rem_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: if (bus.start) begin
        state_d   = LOAD;
        rep_rem_d = bus.repeat_cnt;
        busy_d    = 1'b1;
      end
      LOAD: begin
        state_d   = SHIFT;
        q_d       = N;
        bit_idx_d = 4'd0;
        div_cnt_d = '0;
      end
      SHIFT: if (!bus.pause) begin
        if (div_cnt_q == DIV_M1) begin
          div_cnt_d = '0;
          q_d       = {q_q[14:0], fill};
          bit_idx_d = bit_idx_q + 4'd1;
          if (bit_idx_q == 4'd15) begin
            if (rep_rem_q != 4'd0) begin
              rep_rem_d = rep_rem_q - 4'd1;
              state_d   = LOAD;
            end else begin
              state_d = DONE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end
          end
        end else begin
          div_cnt_d = div_cnt_q + CNT_W'(1);
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // state registers; reset aborts any run without a done pulse
  always_ff @(posedge CLK or negedge n_RESET) begin
    if (!n_RESET) begin
      state_q   <= IDLE;
      q_q       <= '0;
      bit_idx_q <= '0;
      div_cnt_q <= '0;
      rep_rem_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      q_q       <= q_d;
      bit_idx_q <= bit_idx_d;
      div_cnt_q <= div_cnt_d;
      rep_rem_q <= rep_rem_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end
  assign bus.Q       = q_q;
  assign bus.SER     = (state_q == SHIFT) & q_q[15];
  assign bus.bit_idx = bit_idx_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
endmodule
